game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game-flow controller that sequences the player ship and the invader/bullet datapath through attract, play, pause-after-hit, level-clear and game-over phases. It sits between the button conditioning logic, the player block (whose `alive_o` and `add_life_i` it consumes and drives), and the invader field. It gates the per-frame tick so that gameplay freezes outside the play phase. It also owns the level number and the extra-life schedule.

## Interface
- `max_level_p`, 9: highest level (1..15); the level after it wraps to 1.
- `life_every_p`, 2: an extra life is granted when the new level number is a multiple of this value.
- `clear_frames_p`, 60: frame ticks spent in level-clear before the next level starts (1..255).
- `pause_frames_p`, 180: auto-resume timeout in frame ticks (1..255); used only with the configuration macro.

Ports:
- `clk_i`  in  1  system clock.
- `reset_n_i`  in  1  reset; **asynchronous, active-low**.
- `start_i`  in  1  debounced center button (level).
- `frame_tick_i`  in  1  one-cycle pulse per video frame.
- `player_hit_i`  in  1  one-cycle pulse: player struck by an enemy shot.
- `player_alive_i`  in  1  player `alive_o`, sampled in the same cycle as `player_hit_i`.
- `enemies_cleared_i`  in  1  level: all invaders destroyed.
- `run_o`  out  1  gameplay enabled.
- `frame_tick_o`  out  1  gated tick, equal to `frame_tick_i & run_o`.
- `level_reset_o`  out  1  one-cycle pulse: respawn the invaders.
- `add_life_o`  out  1  one-cycle pulse to the player's `add_life_i`.
- `game_over_o`  out  1  high while in OVER.
- `level_o`  out  4  current level (0 = no game started).
- `state_o`  out  5  one-hot present state, for debug.

## Operation
- Start edge: `start_e = start_i & ~start_q`. `start_q` resets to 0, so a button already held when reset releases produces one edge.
- The state register is one-hot: ATTRACT 00001, PLAY 00010, PAUSED 00100, CLEAR 01000, OVER 10000. Any other code recovers to ATTRACT on the next clock.
- ATTRACT: on `start_e`, go to PLAY with `level_o` = 1 and pulse `level_reset_o`.
- PLAY, evaluated in priority order:
  - `player_hit_i & ~player_alive_i` → OVER.
  - `player_hit_i & player_alive_i` → PAUSED.
  - `enemies_cleared_i` → CLEAR, and load the timer with `clear_frames_p`.
  - Otherwise stay in PLAY.
  - A hit takes priority over a simultaneous clear.
- PAUSED: on `start_e`, go to PLAY. The level is unchanged and there is no `level_reset_o` pulse.
- CLEAR:
  - The timer decrements on each `frame_tick_i`.
  - On the tick that takes it from 1 to 0, go to PLAY.
  - At that transition, `level_o` advances to `level_o + 1`, or to 1 if `level_o == max_level_p`, and `level_reset_o` pulses.
  - `add_life_o` also pulses if the new level mod `life_every_p` == 0.
  - `player_hit_i` is ignored in CLEAR.
- OVER: on `start_e`, go to PLAY with `level_o` = 1 and pulse `level_reset_o`. The player restarts itself on the same button.
- `run_o` = 1 only in PLAY.

## Timing
- Reset values: state ATTRACT, `level_o` 0, timer 0, `start_q` 0, and every output 0 (`state_o` = 00001).
- State, `level_o`, `level_reset_o` and `add_life_o` are registered.
  - Each pulse is high for exactly the first cycle in which `state_o` shows PLAY after the qualifying transition.
  - That is one cycle after the triggering input.
- `run_o` and `game_over_o` are decoded from the registered state, so they change one cycle after the triggering input.
- `frame_tick_o` is combinational (0 latency). A tick arriving in the same cycle as a hit is still forwarded.
- Reset asserted mid-operation clears everything immediately and asynchronously. Pulses in flight are dropped.
- `enemies_cleared_i` held high after re-entering PLAY is not re-sampled until the cycle after the `level_reset_o` pulse.

## Configuration
- `GAME_SEQ_AUTO_RESUME_EN` defined:
  - Entering PAUSED loads the timer with `pause_frames_p`.
  - PAUSED exits to PLAY on `start_e` or on the tick that takes the timer from 1 to 0, whichever comes first.
- `GAME_SEQ_AUTO_RESUME_EN` undefined: PAUSED exits only on `start_e`, and `pause_frames_p` is unused.

## Structure
- Package `game_pkg` holds:
  - the `game_state_e` one-hot enum;
  - the state width localparam;
  - `LEVEL_W = 4`.
- Sub-module `frame_timer`:
  - 8-bit loadable down-counter, decremented by `frame_tick_i`;
  - outputs `expire_o`, high on the 1→0 tick;
  - asynchronous active-low reset.
- The sequencer instantiates one `frame_timer`, shared between CLEAR and PAUSED.

## Test plan
- Reset, then a `start_i` rising edge → `state_o` = 00010, `level_o` = 1 and `level_reset_o` high for one cycle, all one cycle after the edge; `run_o` = 1.
- PLAY, `player_hit_i` = 1 with `player_alive_i` = 1 → PAUSED, `run_o` = 0 and `frame_tick_o` stays 0. A start edge then returns to PLAY with `level_o` unchanged and no `level_reset_o`.
- PLAY, `player_hit_i` = 1 with `player_alive_i` = 0 → OVER and `game_over_o` = 1. A start edge then gives `level_o` = 1 and a `level_reset_o` pulse.
- With `clear_frames_p` = 3 at level 1, assert `enemies_cleared_i` → after exactly 3 frame ticks: PLAY, `level_o` = 2, and `level_reset_o` and `add_life_o` pulse together. From level 2 → 3 there is no `add_life_o`.
- With `max_level_p` = 9, clear at level 9 → `level_o` = 1. Hit and clear asserted in the same cycle → PAUSED, not CLEAR.
- With `GAME_SEQ_AUTO_RESUME_EN` and `pause_frames_p` = 2: after a hit, 2 ticks with no start → PLAY. Assert `reset_n_i` low mid-CLEAR → ATTRACT immediately and all outputs 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and helpers for the game-flow sequencer: one-hot phase encoding,
// field widths and the level/extra-life arithmetic.
package game_pkg;

    localparam int STATE_W = 5;
    localparam int LEVEL_W = 4;
    localparam int TIMER_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_ATTRACT = 5'b00001,
        ST_PLAY    = 5'b00010,
        ST_PAUSED  = 5'b00100,
        ST_CLEAR   = 5'b01000,
        ST_OVER    = 5'b10000
    } game_state_e;

    // Level after a cleared level; the top level wraps back to 1.
    function automatic logic [LEVEL_W-1:0] next_level(input logic [LEVEL_W-1:0] level,
                                                      input int max_level);
        if (level == LEVEL_W'(max_level)) begin
            return LEVEL_W'(1);
        end
        return level + 1'b1;
    endfunction

    function automatic logic grants_life(input logic [LEVEL_W-1:0] level, input int every);
        return (32'(level) % every) == 0;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable 8-bit frame down-counter; expire_o marks the tick that takes it from 1 to 0.
module frame_timer
    import game_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               tick_i,
    output logic               expire_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // A load wins over a coincident tick; the counter parks at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = tick_i & ~load_i & (count_q == TIMER_W'(1));

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: attract/play/paused/clear/over phases, level number and
// extra-life schedule. Define GAME_SEQ_AUTO_RESUME_EN to let PAUSED time out to PLAY.
module game_sequencer
    import game_pkg::*;
#(
    parameter int max_level_p    = 9,
    parameter int life_every_p   = 2,
    parameter int clear_frames_p = 60,
    parameter int pause_frames_p = 180
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               start_i,
    input  logic               frame_tick_i,
    input  logic               player_hit_i,
    input  logic               player_alive_i,
    input  logic               enemies_cleared_i,
    output logic               run_o,
    output logic               frame_tick_o,
    output logic               level_reset_o,
    output logic               add_life_o,
    output logic               game_over_o,
    output logic [LEVEL_W-1:0] level_o,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [TIMER_W-1:0] CLEAR_LOAD = TIMER_W'(clear_frames_p);
    localparam logic [TIMER_W-1:0] PAUSE_LOAD = TIMER_W'(pause_frames_p);

    game_state_e        state_q;
    game_state_e        state_d;
    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_d;
    logic               level_reset_q;
    logic               level_reset_d;
    logic               add_life_q;
    logic               add_life_d;
    logic               start_q;
    logic               start_e;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_val;
    logic               timer_expire;

    assign start_e = start_i & ~start_q;

    frame_timer u_frame_timer (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .tick_i     (frame_tick_i),
        .expire_o   (timer_expire)
    );

    // Next-state logic. A hit outranks a simultaneous clear, and a held clear is
    // ignored during the level_reset pulse so the respawned field is not re-cleared.
    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        level_reset_d = 1'b0;
        add_life_d    = 1'b0;
        timer_load    = 1'b0;
        timer_val     = CLEAR_LOAD;

        case (state_q)
            ST_ATTRACT, ST_OVER: begin
                if (start_e) begin
                    state_d       = ST_PLAY;
                    level_d       = LEVEL_W'(1);
                    level_reset_d = 1'b1;
                end
            end

            ST_PLAY: begin
                if (player_hit_i && !player_alive_i) begin
                    state_d = ST_OVER;
                end else if (player_hit_i) begin
                    state_d   = ST_PAUSED;
                    timer_val = PAUSE_LOAD;
`ifdef GAME_SEQ_AUTO_RESUME_EN
                    timer_load = 1'b1;
`else
                    timer_load = 1'b0;
`endif
                end else if (enemies_cleared_i && !level_reset_q) begin
                    state_d    = ST_CLEAR;
                    timer_load = 1'b1;
                end
            end

            ST_PAUSED: begin
`ifdef GAME_SEQ_AUTO_RESUME_EN
                if (start_e || timer_expire) begin
                    state_d = ST_PLAY;
                end
`else
                if (start_e) begin
                    state_d = ST_PLAY;
                end
`endif
            end

            ST_CLEAR: begin
                if (timer_expire) begin
                    state_d       = ST_PLAY;
                    level_d       = next_level(level_q, max_level_p);
                    level_reset_d = 1'b1;
                    add_life_d    = grants_life(level_d, life_every_p);
                end
            end

            default: begin
                state_d = ST_ATTRACT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_ATTRACT;
            level_q       <= '0;
            level_reset_q <= 1'b0;
            add_life_q    <= 1'b0;
            start_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            level_reset_q <= level_reset_d;
            add_life_q    <= add_life_d;
            start_q       <= start_i;
        end
    end

    assign run_o         = (state_q == ST_PLAY);
    assign game_over_o   = (state_q == ST_OVER);
    assign frame_tick_o  = frame_tick_i & run_o;
    assign level_reset_o = level_reset_q;
    assign add_life_o    = add_life_q;
    assign level_o       = level_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed phase walk plus randomized play,
// compared every cycle against a phase-level behavioural model.
module tb_game_sequencer;

    localparam int MAX_LVL    = 9;
    localparam int LIFE_EVERY = 2;
    localparam int CLEAR_FR   = 3;
    localparam int PAUSE_FR   = 2;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       start_i;
    logic       frame_tick_i;
    logic       player_hit_i;
    logic       player_alive_i;
    logic       enemies_cleared_i;
    logic       run_o;
    logic       frame_tick_o;
    logic       level_reset_o;
    logic       add_life_o;
    logic       game_over_o;
    logic [3:0] level_o;
    logic [4:0] state_o;

    int total = 0;
    int bad   = 0;

    string m_phase;
    int    m_level;
    int    m_frames;
    bit    m_start_prev;
    bit    m_lr;
    bit    m_al;

    always #5 clk_i = ~clk_i;

    game_sequencer #(
        .max_level_p    (MAX_LVL),
        .life_every_p   (LIFE_EVERY),
        .clear_frames_p (CLEAR_FR),
        .pause_frames_p (PAUSE_FR)
    ) dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .start_i           (start_i),
        .frame_tick_i      (frame_tick_i),
        .player_hit_i      (player_hit_i),
        .player_alive_i    (player_alive_i),
        .enemies_cleared_i (enemies_cleared_i),
        .run_o             (run_o),
        .frame_tick_o      (frame_tick_o),
        .level_reset_o     (level_reset_o),
        .add_life_o        (add_life_o),
        .game_over_o       (game_over_o),
        .level_o           (level_o),
        .state_o           (state_o)
    );

    function automatic logic [31:0] phaseCode(input string p);
        if (p == "ATTRACT") return 32'd1;
        if (p == "PLAY")    return 32'd2;
        if (p == "PAUSED")  return 32'd4;
        if (p == "CLEAR")   return 32'd8;
        if (p == "OVER")    return 32'd16;
        return 32'd0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_phase      = "ATTRACT";
        m_level      = 0;
        m_frames     = 0;
        m_start_prev = 1'b0;
        m_lr         = 1'b0;
        m_al         = 1'b0;
    endtask

    // Game rules stepped once per clock from the inputs applied for that clock.
    task automatic modelStep();
        bit se;
        bit nlr;
        bit nal;
        bit expire;
        se  = start_i && !m_start_prev;
        nlr = 1'b0;
        nal = 1'b0;
        if (!reset_n_i) begin
            modelReset();
        end else begin
            if (m_phase == "ATTRACT" || m_phase == "OVER") begin
                if (se) begin
                    m_phase = "PLAY";
                    m_level = 1;
                    nlr     = 1'b1;
                end
            end else if (m_phase == "PLAY") begin
                if (player_hit_i && !player_alive_i) begin
                    m_phase = "OVER";
                end else if (player_hit_i) begin
                    m_phase  = "PAUSED";
                    m_frames = PAUSE_FR;
                end else if (enemies_cleared_i && !m_lr) begin
                    m_phase  = "CLEAR";
                    m_frames = CLEAR_FR;
                end
            end else if (m_phase == "PAUSED") begin
                expire = frame_tick_i && (m_frames == 1);
                if (frame_tick_i && m_frames > 0) m_frames--;
`ifdef GAME_SEQ_AUTO_RESUME_EN
                if (se || expire) m_phase = "PLAY";
`else
                if (se) m_phase = "PLAY";
`endif
            end else if (m_phase == "CLEAR") begin
                if (frame_tick_i) begin
                    m_frames--;
                    if (m_frames == 0) begin
                        m_phase = "PLAY";
                        m_level = (m_level == MAX_LVL) ? 1 : m_level + 1;
                        nlr     = 1'b1;
                        nal     = (m_level % LIFE_EVERY) == 0;
                    end
                end
            end
            m_start_prev = start_i;
            m_lr         = nlr;
            m_al         = nal;
        end
    endtask

    task automatic compareAll();
        checkOutput("state",      32'(state_o),       phaseCode(m_phase));
        checkOutput("level",      32'(level_o),       32'(m_level));
        checkOutput("run",        32'(run_o),         32'(m_phase == "PLAY"));
        checkOutput("frame_tick", 32'(frame_tick_o),  32'(frame_tick_i && (m_phase == "PLAY")));
        checkOutput("game_over",  32'(game_over_o),   32'(m_phase == "OVER"));
        checkOutput("lvl_reset",  32'(level_reset_o), 32'(m_lr));
        checkOutput("add_life",   32'(add_life_o),    32'(m_al));
    endtask

    always @(posedge clk_i) begin
        #2;
        compareAll();
    end

    // Drive one clock's worth of inputs; returns just after the edge that consumed them.
    task automatic applyStimulus(input logic s, input logic t, input logic h,
                                 input logic a, input logic c);
        @(negedge clk_i);
        start_i           = s;
        frame_tick_i      = t;
        player_hit_i      = h;
        player_alive_i    = a;
        enemies_cleared_i = c;
        modelStep();
        @(posedge clk_i);
        #3;
    endtask

    task automatic releaseReset();
        @(negedge clk_i);
        reset_n_i         = 1'b1;
        start_i           = 1'b0;
        frame_tick_i      = 1'b0;
        player_hit_i      = 1'b0;
        player_alive_i    = 1'b1;
        enemies_cleared_i = 1'b0;
        modelStep();
        @(posedge clk_i);
        #3;
    endtask

    task automatic doClear();
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 1);
        for (int i = 0; i < CLEAR_FR; i++) applyStimulus(0, 1, 0, 1, 0);
    endtask

    initial begin
        reset_n_i         = 1'b0;
        start_i           = 1'b0;
        frame_tick_i      = 1'b0;
        player_hit_i      = 1'b0;
        player_alive_i    = 1'b1;
        enemies_cleared_i = 1'b0;
        modelReset();

        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("lit_reset_state", 32'(state_o), 32'h01);
        checkOutput("lit_reset_level", 32'(level_o), 32'h0);
        checkOutput("lit_reset_outs",  32'({run_o, frame_tick_o, level_reset_o, add_life_o, game_over_o}), 32'h0);
        applyStimulus(0, 0, 0, 1, 0);
        releaseReset();

        // Start from attract
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("lit_start_state", 32'(state_o), 32'h02);
        checkOutput("lit_start_level", 32'(level_o), 32'd1);
        checkOutput("lit_start_lr",    32'(level_reset_o), 32'd1);
        checkOutput("lit_start_run",   32'(run_o), 32'd1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("lit_start_lr_off", 32'(level_reset_o), 32'd0);

        // Level 1 -> 2 grants a life, 2 -> 3 does not
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("lit_clear_state", 32'(state_o), 32'h08);
        applyStimulus(0, 1, 0, 1, 0);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("lit_clear_wait", 32'(state_o), 32'h08);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("lit_clear_done",  32'(state_o), 32'h02);
        checkOutput("lit_level2",      32'(level_o), 32'd2);
        checkOutput("lit_level2_lr",   32'(level_reset_o), 32'd1);
        checkOutput("lit_level2_life", 32'(add_life_o), 32'd1);
        doClear();
        checkOutput("lit_level3",      32'(level_o), 32'd3);
        checkOutput("lit_level3_lr",   32'(level_reset_o), 32'd1);
        checkOutput("lit_level3_life", 32'(add_life_o), 32'd0);
        applyStimulus(0, 0, 0, 1, 0);

        // Hit with a tick in the same cycle: the tick is still forwarded
        @(negedge clk_i);
        start_i = 0; frame_tick_i = 1; player_hit_i = 1; player_alive_i = 1; enemies_cleared_i = 0;
        modelStep();
        #1;
        checkOutput("lit_tick_fwd", 32'(frame_tick_o), 32'd1);
        @(posedge clk_i);
        #3;
        checkOutput("lit_pause_state", 32'(state_o), 32'h04);
        checkOutput("lit_pause_run",   32'(run_o), 32'd0);
        checkOutput("lit_pause_tick",  32'(frame_tick_o), 32'd0);
        applyStimulus(0, 1, 0, 1, 0);
        applyStimulus(0, 1, 0, 1, 0);
`ifdef GAME_SEQ_AUTO_RESUME_EN
        checkOutput("lit_auto_resume", 32'(state_o), 32'h02);
        checkOutput("lit_auto_level",  32'(level_o), 32'd3);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("lit_pause2_state", 32'(state_o), 32'h04);
`else
        checkOutput("lit_pause_hold", 32'(state_o), 32'h04);
`endif
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("lit_resume_state", 32'(state_o), 32'h02);
        checkOutput("lit_resume_level", 32'(level_o), 32'd3);
        checkOutput("lit_resume_lr",    32'(level_reset_o), 32'd0);
        applyStimulus(0, 0, 0, 1, 0);

        // Fatal hit, then restart
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("lit_over_state", 32'(state_o), 32'h10);
        checkOutput("lit_over_flag",  32'(game_over_o), 32'd1);
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("lit_restart_level", 32'(level_o), 32'd1);
        checkOutput("lit_restart_lr",    32'(level_reset_o), 32'd1);
        applyStimulus(0, 0, 0, 1, 0);

        // Hit and clear together
        applyStimulus(0, 0, 1, 1, 1);
        checkOutput("lit_hit_over_clear", 32'(state_o), 32'h04);
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);

        // Walk to the top level and wrap
        for (int i = 0; i < MAX_LVL - 1; i++) doClear();
        checkOutput("lit_level_max", 32'(level_o), 32'(MAX_LVL));
        doClear();
        checkOutput("lit_wrap_level", 32'(level_o), 32'd1);
        checkOutput("lit_wrap_lr",    32'(level_reset_o), 32'd1);
        checkOutput("lit_wrap_life",  32'(add_life_o), 32'd0);

        // Asynchronous reset in the middle of CLEAR
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 1, 0, 1, 0);
        frame_tick_i = 1'b1;
        reset_n_i    = 1'b0;
        modelReset();
        #1;
        checkOutput("lit_areset_state", 32'(state_o), 32'h01);
        checkOutput("lit_areset_level", 32'(level_o), 32'h0);
        checkOutput("lit_areset_outs",  32'({run_o, frame_tick_o, level_reset_o, add_life_o, game_over_o}), 32'h0);
        applyStimulus(0, 0, 0, 1, 0);
        releaseReset();

        // Randomized play
        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 3) == 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 19) == 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 5) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
